// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts one fetch PC at a time and returns the
// addressed 32-bit word LATENCY cycles later, with a loader write port that can
// fill program memory in any state. Misaligned or out-of-range PCs answer with
// NOP_WORD and resp_fault set.
//
// Handshake: a transfer happens on a rising edge where valid && ready. The
// responder raises req_ready when idle, or when its current response is being
// consumed in the same cycle. While resp_valid && !resp_ready the response
// fields do not change.
module imem_responder #(
   parameter int          DEPTH_WORDS = 64,
   parameter int          LATENCY     = 2,
   parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic [63:0]                    req_pc,
   output logic                           resp_valid,
   input  logic                           resp_ready,
   output logic [31:0]                    resp_instr,
   output logic [63:0]                    resp_pc,
   output logic                           resp_fault,
   input  logic                           load_en,
   input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
   input  logic [31:0]                    load_data,
   output logic                           busy,
   output logic [1:0]                     dbg_state
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [3:0]  count;
   logic [3:0]  count_next;
   logic [63:0] pend_pc;
   logic        pend_fault;

   logic        accept;
   logic        req_fault;
   logic        load_resp;
   logic [63:0] rd_pc;
   logic        rd_fault;
   logic [AW-1:0] rd_idx;
   logic [31:0] rd_word;
   logic [31:0] resp_word;

   logic [31:0] mem [DEPTH_WORDS];

   // Handshake, fault decode, next-state and the word to capture into resp_*.
   always_comb begin
      state_next = state;
      count_next = count;
      load_resp  = 1'b0;
      rd_pc      = pend_pc;
      rd_fault   = pend_fault;

      req_ready  = (state == IDLE) || ((state == RESP) && resp_ready);
      accept     = req_valid && req_ready;
      // DEPTH_WORDS is a power of two, so any set bit above the index field
      // means the word index is out of range.
      req_fault  = (req_pc[1:0] != 2'b00) || (|req_pc[63:AW+2]);

      case (state)
         WAIT: begin
            count_next = count - 4'd1;
            if (count == 4'd1) begin
               load_resp  = 1'b1;
               state_next = RESP;
            end
         end
         RESP: begin
            if (resp_ready) state_next = IDLE;
         end
         default: ;
      endcase

      // Acceptance is only possible from IDLE or a consumed RESP, so it
      // overrides whatever the case statement chose.
      if (accept) begin
         if (LATENCY == 1) begin
            state_next = RESP;
            load_resp  = 1'b1;
            rd_pc      = req_pc;
            rd_fault   = req_fault;
         end else begin
            state_next = WAIT;
            count_next = 4'(LATENCY - 1);
         end
      end

      // Write-first: a load to the word being read this edge is forwarded.
      rd_idx    = rd_pc[AW+1:2];
      rd_word   = (load_en && (load_addr == rd_idx)) ? load_data : mem[rd_idx];
      resp_word = rd_fault ? NOP_WORD : rd_word;

      resp_valid = (state == RESP);
      busy       = (state != IDLE);
      dbg_state  = state;
   end

   // FSM state, pending request and response registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         count      <= 4'd0;
         pend_pc    <= 64'd0;
         pend_fault <= 1'b0;
         resp_instr <= NOP_WORD;
         resp_pc    <= 64'd0;
         resp_fault <= 1'b0;
      end else begin
         state <= state_next;
         count <= count_next;
         if (accept) begin
            pend_pc    <= req_pc;
            pend_fault <= req_fault;
         end
         if (load_resp) begin
            resp_instr <= resp_word;
            resp_pc    <= rd_pc;
            resp_fault <= rd_fault;
         end
      end
   end

   // Program memory: NOP fill on reset, otherwise loader writes.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= NOP_WORD;
      end else if (load_en) begin
         mem[load_addr] <= load_data;
      end
   end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder: the memory end of the fetch interface.
- Accepts a 64-bit byte-address PC request from the fetch stage and returns the 32-bit instruction after a fixed programmable latency.
- Includes a loader write port so the bench or boot logic can fill program memory.
- One outstanding request. Misaligned or out-of-range PCs return a NOP with a fault flag.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit instruction words (power of 2, 4..1024).
- LATENCY, 2, cycles from request acceptance to resp_valid (1..15).
- NOP_WORD, 32'h00000013, value returned on fault and reset fill value (addi x0,x0,0).

Ports:
- clock  in  1  single clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  fetch presents a PC.
- req_ready  out  1  responder can accept a request this cycle.
- req_pc  in  64  byte address of the instruction.
- resp_valid  out  1  response available.
- resp_ready  in  1  fetch consumes the response this cycle.
- resp_instr  out  32  instruction word.
- resp_pc  out  64  PC of the request being answered.
- resp_fault  out  1  1 = misaligned (req_pc[1:0]!=0) or word index >= DEPTH_WORDS.
- load_en  in  1  write one word into memory.
- load_addr  in  $clog2(DEPTH_WORDS)  word index.
- load_data  in  32  word to write.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, resp_valid=0, resp_instr=NOP_WORD, resp_pc=0, resp_fault=0, count=0. All DEPTH_WORDS words are filled with NOP_WORD in the same cycle. Any outstanding request is dropped and no response is issued. Reset overrides load_en.
- Handshake: a transfer occurs on a rising edge where valid && ready.
- req_ready = (state==IDLE) || (state==RESP && resp_ready).
- resp_valid is high only in RESP. resp_instr, resp_pc and resp_fault are stable while resp_valid && !resp_ready.
- States:
  - IDLE: on req accept, capture pc into pend_pc and compute pend_fault. If LATENCY==1, go to RESP and load outputs at that edge. Otherwise count=LATENCY-1 and go to WAIT.
  - WAIT: count decrements each cycle. At the edge where count==1: load resp_* and go to RESP.
  - RESP: on resp_ready with no new request, go to IDLE and clear resp_valid. On resp_ready with a new req accepted, behave as the IDLE acceptance (back-to-back). Outputs are replaced on that edge and resp_valid stays high only if LATENCY==1; otherwise resp_valid goes low and state is WAIT.
- Latency: request accepted at edge k gives resp_valid high after edge k+LATENCY.
- Sustained throughput: one instruction per LATENCY cycles when resp_ready is held high (LATENCY==1: one per cycle).
- Read timing: memory is read at the edge that loads resp_*.
- Loader write on the same edge to the same word: load_data is forwarded to resp_instr (write-first).
- Earlier loads are always visible. Loads after the read edge do not alter a held response.
- Fault computation:
  - word index = req_pc[63:2].
  - fault if req_pc[1:0]!=0 or req_pc[63:2] >= DEPTH_WORDS.
  - On fault, resp_instr=NOP_WORD, resp_fault=1, and resp_pc still equals req_pc.
- Loads: load_en writes mem[load_addr] in any state and does not affect the request FSM. load_addr is exactly index-width, so no out-of-range load exists.
- req_valid while req_ready=0 is ignored (not queued). The fetch stage must hold it.
- resp_ready while !resp_valid has no effect.

Test Plan:
- Reset, then read PC 0, 4, 252 with LATENCY=2 and no loads: resp_instr=32'h00000013, fault=0, resp_valid exactly 2 cycles after each accept.
- Load word 3 = 32'h00A30333, then request PC 12: resp_instr=32'h00A30333, resp_pc=12, fault=0. Hold resp_ready=0 for 5 cycles: outputs stable, req_ready=0.
- Request PC 10 (misaligned) and PC 256 (index 64 >= DEPTH): each gives resp_instr=32'h00000013, resp_fault=1, resp_pc echoed (10 and 256).
- Load word 5 = 32'hDEADBEEF on the same edge the response for PC 20 is captured: resp_instr=32'hDEADBEEF. Load word 5 = 32'h0 one cycle later while response held: resp_instr stays 32'hDEADBEEF.
- LATENCY=1 with resp_ready=1 and req_valid=1 for PCs 0,4,8,12 on consecutive cycles: four back-to-back responses, one per cycle, in order, resp_valid continuously high.
- Assert reset for one cycle while in WAIT after a request for PC 4: no response issued, state IDLE, resp_valid=0, previously loaded words read back as 32'h00000013.
